// File: rtl/ram_line_pkg.sv
// ram_line_pkg: shared definitions for the single-line RAM cache controller.
//   - Default address/data widths of the external burst RAM (4M x 32).
//   - Line geometry: 8 words per line, 3-bit word offset, tag = upper bits.
//   - Controller state encoding (exposed on the debug port of ram_line_ctrl).
package ram_line_pkg;

  localparam int RAM_ADDR_W = 22;
  localparam int RAM_DATA_W = 32;
  localparam int LINE_WORDS = 8;
  localparam int OFFS_W     = 3;
  localparam int TAG_W      = RAM_ADDR_W - OFFS_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL_REQ = 3'd1,
    ST_FILL     = 3'd2,
    ST_WB_REQ   = 3'd3,
    ST_WB       = 3'd4,
    ST_ACK      = 3'd5
  } state_e;

endpackage

// File: rtl/ram_line_buf.sv
// ram_line_buf: 8-word line data store.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all words)
//   fill_we_i/idx/data: fill-beat write request
//   merge_we_i/idx/data: CPU word write request; wins over a fill beat
//                        issued in the same cycle
//   rd_a_idx_i/data_o : asynchronous read port for CPU read data
//   rd_b_idx_i/data_o : asynchronous read port for write-back beats
module ram_line_buf
  import ram_line_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_we_i,
  input  logic [OFFS_W-1:0] fill_idx_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              merge_we_i,
  input  logic [OFFS_W-1:0] merge_idx_i,
  input  logic [DATA_W-1:0] merge_data_i,
  input  logic [OFFS_W-1:0] rd_a_idx_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [OFFS_W-1:0] rd_b_idx_i,
  output logic [DATA_W-1:0] rd_b_data_o
);

  logic [DATA_W-1:0] mem_q [LINE_WORDS];

  logic              wr_en;
  logic [OFFS_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = fill_we_i | merge_we_i;
    wr_idx  = merge_we_i ? merge_idx_i  : fill_idx_i;
    wr_data = merge_we_i ? merge_data_i : fill_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_a_data_o = mem_q[rd_a_idx_i];
  assign rd_b_data_o = mem_q[rd_b_idx_i];

endmodule

// File: rtl/ram_line_ctrl.sv
// ram_line_ctrl: single-line write-through cache between the CPU data port
// and an external 8-word wrapping burst RAM.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   cpu_stb/we/addr/din    : CPU request (held until cpu_ack)
//   cpu_dout, cpu_ack      : registered read data, one-cycle completion pulse
//   ram_stb/we/addr        : one-cycle burst request
//   ram_dout               : write-beat data (valid while in write burst)
//   ram_din, ram_ack       : read-beat data, one ack per beat (8 per burst)
//   dbg_state, dbg_valid   : controller state and line-valid bit for observation
//
// Handshakes: a CPU request is accepted only in ST_IDLE and completes with a
// single cpu_ack pulse; the RAM side is a one-cycle ram_stb followed by
// exactly 8 consecutive ram_ack beats, and no new ram_stb is issued before
// the 8th ack of the previous burst.
//
// Build option: define RAM_LINE_CTRL_CWF_EN for critical-word forwarding on
// read misses (ack one cycle after fill beat 0, fill finishes in background).
module ram_line_ctrl
  import ram_line_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_stb,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              ram_stb,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  input  logic              ram_ack,
  output state_e            dbg_state,
  output logic              dbg_valid
);

  localparam int TAG_BITS = ADDR_W - OFFS_W;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [OFFS_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                cwf_ack_q, cwf_ack_d;

  logic                fill_we, merge_we;
  logic [OFFS_W-1:0]   fill_idx, merge_idx, rd_a_idx;
  logic [DATA_W-1:0]   merge_data, rd_a_data, rd_b_data;
  logic                hit;

  assign hit      = valid_q && (tag_q == cpu_addr[ADDR_W-1:OFFS_W]);
  // Fill beats arrive critical-word first and wrap inside the line.
  assign fill_idx = addr_q[OFFS_W-1:0] + beat_q;

  ram_line_buf #(.DATA_W(DATA_W)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_we_i    (fill_we),
    .fill_idx_i   (fill_idx),
    .fill_data_i  (ram_din),
    .merge_we_i   (merge_we),
    .merge_idx_i  (merge_idx),
    .merge_data_i (merge_data),
    .rd_a_idx_i   (rd_a_idx),
    .rd_a_data_o  (rd_a_data),
    .rd_b_idx_i   (beat_q),
    .rd_b_data_o  (rd_b_data)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    beat_d     = beat_q;
    dout_d     = dout_q;
    cwf_ack_d  = 1'b0;
    fill_we    = 1'b0;
    merge_we   = 1'b0;
    merge_idx  = addr_q[OFFS_W-1:0];
    merge_data = din_q;
    rd_a_idx   = addr_q[OFFS_W-1:0];
    cpu_ack    = cwf_ack_q;
    ram_stb    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_dout   = '0;

    case (state_q)
      ST_IDLE: begin
        rd_a_idx = cpu_addr[OFFS_W-1:0];
        if (cpu_stb) begin
          we_d   = cpu_we;
          addr_d = cpu_addr;
          din_d  = cpu_din;
          if (hit && !cpu_we) begin
            dout_d  = rd_a_data;
            state_d = ST_ACK;
          end else if (hit) begin
            merge_we   = 1'b1;
            merge_idx  = cpu_addr[OFFS_W-1:0];
            merge_data = cpu_din;
            state_d    = ST_WB_REQ;
          end else begin
            state_d = ST_FILL_REQ;
          end
        end
      end

      ST_FILL_REQ: begin
        ram_stb = 1'b1;
        ram_addr = addr_q;
        beat_d  = '0;
        // Line contents are about to be overwritten.
        valid_d = 1'b0;
        state_d = ST_FILL;
      end

      ST_FILL: begin
        if (ram_ack) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          // Beat 0 carries the CPU's own word; a pending write replaces it
          // as it lands, so every other fill beat is stored unmodified.
          if (we_q && (beat_q == '0)) merge_we = 1'b1;
`ifdef RAM_LINE_CTRL_CWF_EN
          if (!we_q && (beat_q == '0)) begin
            dout_d    = ram_din;
            cwf_ack_d = 1'b1;
          end
`endif
          if (beat_q == '1) begin
            valid_d = 1'b1;
            tag_d   = addr_q[ADDR_W-1:OFFS_W];
            if (we_q) begin
              state_d = ST_WB_REQ;
            end else begin
`ifdef RAM_LINE_CTRL_CWF_EN
              state_d = ST_IDLE;
`else
              // Critical word was stored on beat 0, so it is readable now.
              dout_d  = rd_a_data;
              state_d = ST_ACK;
`endif
            end
          end
        end
      end

      ST_WB_REQ: begin
        ram_stb  = 1'b1;
        ram_we   = 1'b1;
        ram_addr = {tag_q, {OFFS_W{1'b0}}};
        beat_d   = '0;
        state_d  = ST_WB;
      end

      ST_WB: begin
        ram_dout = rd_b_data;
        if (ram_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        cpu_ack = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      beat_q    <= '0;
      dout_q    <= '0;
      cwf_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      beat_q    <= beat_d;
      dout_q    <= dout_d;
      cwf_ack_q <= cwf_ack_d;
    end
  end

  assign cpu_dout  = dout_q;
  assign dbg_state = state_q;
  assign dbg_valid = valid_q;

endmodule

// File: tb/tb_ram_line_ctrl.sv
// tb_ram_line_ctrl: directed bench for ram_line_ctrl with a behavioural
// burst RAM (read latency 5, write latency 4 from ram_stb) and scoreboards
// for expected bursts, write-beat data and CPU acks.
module tb_ram_line_ctrl;
  import ram_line_pkg::*;

`ifdef RAM_LINE_CTRL_CWF_EN
  localparam int RD_MISS_ACK = 7;
`else
  localparam int RD_MISS_ACK = 14;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_stb, cpu_we;
  logic [21:0] cpu_addr;
  logic [31:0] cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        ram_stb, ram_we;
  logic [21:0] ram_addr;
  logic [31:0] ram_dout, ram_din;
  logic        ram_ack;
  state_e      dbg_state;
  logic        dbg_valid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int ram_beat = -1;

  logic [40:0] ack_exp_q[$];  // {is_read, data, rel_cycle}
  logic [30:0] bst_exp_q[$];  // {we, addr, rel_cycle}
  logic [31:0] wb_exp_q[$];   // write beat data in beat order
  logic [31:0] mem [int];

  ram_line_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din), .ram_ack(ram_ack),
    .dbg_state(dbg_state), .dbg_valid(dbg_valid)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] pat(input logic [21:0] a);
    return 32'h12340101 | ({29'd0, a[2:0]} << 12);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [21:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return pat(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ack(input logic rd, input logic [31:0] d, input int c);
    ack_exp_q.push_back({rd, d, 8'(c)});
  endtask

  task automatic exp_bst(input logic we, input logic [21:0] a, input int c);
    bst_exp_q.push_back({we, a, 8'(c)});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_cpu_ack"},  64'(cpu_ack),   64'd0);
    chk({tag, "_cpu_dout"}, 64'(cpu_dout),  64'd0);
    chk({tag, "_ram_stb"},  64'(ram_stb),   64'd0);
    chk({tag, "_ram_we"},   64'(ram_we),    64'd0);
    chk({tag, "_ram_addr"}, 64'(ram_addr),  64'd0);
    chk({tag, "_ram_dout"}, 64'(ram_dout),  64'd0);
    chk({tag, "_valid"},    64'(dbg_valid), 64'd0);
    chk({tag, "_state"},    64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic cpu_req(input string tag, input logic we, input logic [21:0] a,
                         input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    cpu_stb = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    cpu_stb = 1'b0;
  endtask

  task automatic settle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE && ram_ack === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("settle_idle", 64'(ok), 64'd1);
  endtask

  // ---------------- RAM model (drives ram_ack / ram_din) ----------------
  initial begin : ram_model
    logic [30:0] e;
    logic        bwe;
    logic [21:0] ba;
    logic [2:0]  off;
    ram_ack = 1'b0;
    ram_din = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && ram_stb === 1'b1) begin
        bwe = ram_we;
        ba  = ram_addr;
        if (bst_exp_q.size() == 0) begin
          chk("burst_unexpected", 64'(bst_exp_q.size()), 64'd1);
        end else begin
          e = bst_exp_q.pop_front();
          chk("burst_req", 64'({bwe, ba, 8'(cyc - t0)}), 64'(e));
        end
        repeat (bwe ? 4 : 5) @(posedge clk);
        for (int k = 0; k < 8; k++) begin
          #1;
          if (!rst_n) break;
          off      = ba[2:0] + 3'(k);
          ram_beat = k;
          ram_ack  = 1'b1;
          ram_din  = bwe ? 32'd0 : mem_rd({ba[21:3], off});
          @(negedge clk);
          chk("stb_while_busy", 64'(ram_stb), 64'd0);
          if (bwe) begin
            if (wb_exp_q.size() == 0)
              chk("wb_beat_unexpected", 64'(wb_exp_q.size()), 64'd1);
            else
              chk("wb_beat_data", 64'(ram_dout), 64'(wb_exp_q.pop_front()));
            mem[int'({ba[21:3], off})] = ram_dout;
          end
          @(posedge clk);
        end
        #1;
        ram_ack  = 1'b0;
        ram_din  = '0;
        ram_beat = -1;
      end
    end
  end

  // ---------------- CPU ack monitor / scoreboard ----------------
  initial begin : ack_mon
    logic [40:0] e;
    forever begin
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        if (ack_exp_q.size() == 0) begin
          chk("ack_unexpected", 64'(ack_exp_q.size()), 64'd1);
        end else begin
          e = ack_exp_q.pop_front();
          chk("ack_cycle", 64'(8'(cyc - t0)), 64'(e[7:0]));
          if (e[40]) chk("ack_rdata", 64'(cpu_dout), 64'(e[39:8]));
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    logic found;
    cpu_stb = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset");

    // Read miss, critical word first from 0x351B05.
    exp_bst(1'b0, 22'h351B05, 1);
    exp_ack(1'b1, 32'h12345101, RD_MISS_ACK);
    cpu_req("rd_miss", 1'b0, 22'h351B05, '0);
    settle();

    // Read hit in the same line.
    exp_ack(1'b1, 32'h12342101, 1);
    cpu_req("rd_hit", 1'b0, 22'h351B02, '0);
    settle();

    // Write hit: one write burst of the whole line with word 3 replaced.
    exp_bst(1'b1, 22'h351B00, 1);
    for (int k = 0; k < 8; k++)
      wb_exp_q.push_back(k == 3 ? 32'hDEADBEEF : pat(22'h351B00 + 22'(k)));
    exp_ack(1'b0, '0, 13);
    cpu_req("wr_hit", 1'b1, 22'h351B03, 32'hDEADBEEF);
    settle();
    chk("dout_hold_after_write", 64'(cpu_dout), 64'h12342101);

    // Write miss: fill from 0x351B17, then write-back with merged word 7.
    exp_bst(1'b0, 22'h351B17, 1);
    exp_bst(1'b1, 22'h351B10, 14);
    for (int k = 0; k < 8; k++)
      wb_exp_q.push_back(k == 7 ? 32'hCAFEF00D : pat(22'h351B10 + 22'(k)));
    exp_ack(1'b0, '0, 26);
    cpu_req("wr_miss", 1'b1, 22'h351B17, 32'hCAFEF00D);
    settle();

    exp_ack(1'b1, 32'hCAFEF00D, 1);
    cpu_req("rd_merged", 1'b0, 22'h351B17, '0);
    settle();
    exp_ack(1'b1, 32'h12342101, 1);
    cpu_req("rd_line_b12", 1'b0, 22'h351B12, '0);
    settle();

    // Line crossing: tag 0x6A35F then 0x6A360.
    exp_bst(1'b0, 22'h351AFF, 1);
    exp_ack(1'b1, 32'h12347101, RD_MISS_ACK);
    cpu_req("rd_aff", 1'b0, 22'h351AFF, '0);
    settle();
    exp_bst(1'b0, 22'h351B00, 1);
    exp_ack(1'b1, 32'h12340101, RD_MISS_ACK);
    cpu_req("rd_b00", 1'b0, 22'h351B00, '0);
    settle();
    exp_ack(1'b1, 32'hDEADBEEF, 1);
    cpu_req("rd_b03_written", 1'b0, 22'h351B03, '0);
    settle();

    // Reset during fill beat 3.
    exp_bst(1'b0, 22'h351A00, 1);
`ifdef RAM_LINE_CTRL_CWF_EN
    exp_ack(1'b1, 32'h12340101, 7);
`endif
    @(posedge clk); #1;
    t0 = cyc;
    cpu_stb = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h351A00; cpu_din = '0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_ack === 1'b1 && ram_beat == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("beat3_reached", 64'(found), 64'd1);
    rst_n = 1'b0;
    cpu_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("mid_fill_reset");

    exp_bst(1'b0, 22'h351A00, 1);
    exp_ack(1'b1, 32'h12340101, RD_MISS_ACK);
    cpu_req("rd_after_reset", 1'b0, 22'h351A00, '0);
    settle();

    repeat (4) @(posedge clk);
    chk("ack_q_drained", 64'(ack_exp_q.size()), 64'd0);
    chk("burst_q_drained", 64'(bst_exp_q.size()), 64'd0);
    chk("wb_q_drained", 64'(wb_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
